// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared state encoding and default widths for the instruction memory arbiter
package imem_arb_pkg;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_ADDR_BITS = 16;
    localparam logic [63:0] ERR_INSTR = 64'h0;
endpackage

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, loader and memory-side signals of the instruction memory arbiter
interface imem_port_arbiter_if #(
    parameter int WORD_SIZE = imem_arb_pkg::DEF_WORD_SIZE,
    parameter int ADDR_BITS = imem_arb_pkg::DEF_ADDR_BITS
);
    logic                 FetchReqValid;
    logic                 FetchReqReady;
    logic [63:0]          FetchAddress;
    logic                 FetchRspValid;
    logic                 FetchRspReady;
    logic [WORD_SIZE-1:0] FetchInstruction;
    logic                 FetchError;
    logic                 LoadReqValid;
    logic                 LoadReqReady;
    logic [ADDR_BITS-1:0] LoadAddress;
    logic [WORD_SIZE-1:0] LoadData;
    logic                 LoadAck;
    logic                 MemWrite;
    logic [ADDR_BITS-1:0] MemAddress;
    logic [WORD_SIZE-1:0] MemWData;
    logic [WORD_SIZE-1:0] MemRData;

    modport slave (
        input  FetchReqValid, FetchAddress, FetchRspReady,
        input  LoadReqValid, LoadAddress, LoadData, MemRData,
        output FetchReqReady, FetchRspValid, FetchInstruction, FetchError,
        output LoadReqReady, LoadAck, MemWrite, MemAddress, MemWData
    );

    modport master (
        output FetchReqValid, FetchAddress, FetchRspReady,
        output LoadReqValid, LoadAddress, LoadData, MemRData,
        input  FetchReqReady, FetchRspValid, FetchInstruction, FetchError,
        input  LoadReqReady, LoadAck, MemWrite, MemAddress, MemWData
    );
endinterface

// File: rtl/imem_rr_arbiter.sv
// imem_rr_arbiter: 2-way round-robin grant, bit 0 = loader, bit 1 = fetch
module imem_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    logic last_load;

    // a tie goes to whoever did not win last; reset pretends fetch won so loader goes first
    always_comb gnt = (&req) ? (last_load ? 2'b10 : 2'b01) : req;

    always_ff @(posedge clk or posedge rst)
        if (rst) last_load <= 1'b0;
        else if (adv) last_load <= gnt[0];
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one synchronous instruction memory between a fetch port and a loader
module imem_port_arbiter #(
    parameter int WORD_SIZE = imem_arb_pkg::DEF_WORD_SIZE,
    parameter int ADDR_BITS = imem_arb_pkg::DEF_ADDR_BITS
) (
    input logic                Clock,
    input logic                Reset,
    imem_port_arbiter_if.slave bus
);
    import imem_arb_pkg::*;

    state_t               state, state_nx;
    logic [1:0]           gnt;
    logic                 idle, fetch_go, load_go, fetch_err;
    logic [ADDR_BITS-1:0] fetch_idx, mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata, rsp_instr;
    logic                 mem_write, load_ack, rsp_valid, rsp_err;

    assign idle      = state == IDLE;
    assign fetch_go  = gnt[1];
    assign load_go   = gnt[0];
    assign fetch_idx = bus.FetchAddress[ADDR_BITS+1:2];
    assign fetch_err = (|bus.FetchAddress[1:0]) || (|bus.FetchAddress[63:ADDR_BITS+2]);

    // requests are masked outside IDLE, so a grant always means a transfer this cycle
    imem_rr_arbiter u_rr (
        .clk(Clock),
        .rst(Reset),
        .req({bus.FetchReqValid & idle, bus.LoadReqValid & idle}),
        .adv(|gnt),
        .gnt(gnt)
    );

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = load_go ? WRITE : fetch_go ? (fetch_err ? RESP : READ) : IDLE;
            READ:    state_nx = RESP;
            WRITE:   state_nx = IDLE;
            RESP:    state_nx = bus.FetchRspReady ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // memory strobes are registered so MemWrite and LoadAck line up with the WRITE state
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            mem_write <= 1'b0;
            load_ack  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_instr <= '0;
        end else begin
            mem_write <= load_go;
            load_ack  <= load_go;
            if (load_go) begin
                mem_addr  <= bus.LoadAddress;
                mem_wdata <= bus.LoadData;
            end else if (fetch_go && !fetch_err) mem_addr <= fetch_idx;
            if (fetch_go && fetch_err) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_instr <= ERR_INSTR[WORD_SIZE-1:0];
            end else if (state == READ) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_instr <= bus.MemRData;
            end else if (state == RESP && bus.FetchRspReady) rsp_valid <= 1'b0;
        end

    always_comb begin
        bus.FetchReqReady    = fetch_go;
        bus.LoadReqReady     = load_go;
        bus.FetchRspValid    = rsp_valid;
        bus.FetchInstruction = rsp_instr;
        bus.FetchError       = rsp_err;
        bus.LoadAck          = load_ack;
        bus.MemWrite         = mem_write;
        bus.MemAddress       = mem_addr;
        bus.MemWData         = mem_wdata;
    end
endmodule
